spi_slave_sync: RTL and testbench



---
 rtl/spi_slave_sync.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: oversampling SPI slave; the pins are synchronised into clk and every CPOL/CPHA mode is supported.
// Latency: a pin edge acts SYNC_STAGES+1 clk after it; miso and rx_valid follow one cycle later.
// Backpressure: tx uses a 1-deep holding register (tx_ready = empty); an unaccepted rx word causes new words to drop (rx_overrun).
//
// Ports: clk, rst (async, active-high); sclk/ss_n/mosi async pins; miso/miso_oe pad drive;
//        cpol/cpha mode (captured at frame start); tx_data/tx_valid/tx_ready; rx_data/rx_valid/rx_ready;
//        busy; tx_underrun/rx_overrun/frame_err single-cycle pulses.
// Option: define SPI_SLV_LSB_FIRST_EN to add input lsb_first (captured at frame start). Without it the block is MSB first only.
module spi_slave_sync #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic                  cpol,
   input  logic                  cpha,
`ifdef SPI_SLV_LSB_FIRST_EN
   input  logic                  lsb_first,
`endif
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  busy,
   output logic                  tx_underrun,
   output logic                  rx_overrun,
   output logic                  frame_err
);
   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT_HIGH} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
   logic                    sclk_prev_q, sclk_prev_d;
   logic                    ss_prev_q, ss_prev_d;
   logic                    cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
   logic [DATA_WIDTH-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    miso_q, miso_d;
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic                    hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    underrun_q, underrun_d;
   logic                    overrun_q, overrun_d;
   logic                    frame_err_q, frame_err_d;

   logic                    sclk_s, ss_s, mosi_s, lsb_in;
   logic                    sclk_rise, sclk_fall, ss_fall, ss_rise;
   logic                    lead_e, trail_e, sample_e, drive_e;
   logic                    reload, word_done;
   logic [DATA_WIDTH-1:0]   reload_word, shift_in;

`ifdef SPI_SLV_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_WIDTH-1];
   endfunction

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign ss_fall   = ~ss_s & ss_prev_q;
   assign ss_rise   = ss_s & ~ss_prev_q;
   // Leading edge leaves the idle level given by cpol; CPHA picks which edge samples.
   assign lead_e    = cpol_q ? sclk_fall : sclk_rise;
   assign trail_e   = cpol_q ? sclk_rise : sclk_fall;
   assign sample_e  = cpha_q ? trail_e : lead_e;
   assign drive_e   = cpha_q ? lead_e : trail_e;
   // An empty holding register reloads zeros; a same-cycle tx_valid is not bypassed.
   assign reload_word = hold_full_q ? hold_q : '0;
   // Received bits enter at the end opposite to the one being transmitted.
   assign shift_in  = lsb_q ? {mosi_s, sr_q[DATA_WIDTH-1:1]} : {sr_q[DATA_WIDTH-2:0], mosi_s};

   always_comb begin
      state_d     = state_q;
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_d = sclk_s;
      ss_prev_d   = ss_s;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      lsb_d       = lsb_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      miso_d      = miso_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      reload      = 1'b0;
      word_done   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (ss_fall) begin
               state_d = ST_SHIFT;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_in;
               cnt_d   = '0;
               // CPHA=0 needs the first bit on the wire before the first sclk edge.
               if (!cpha) begin
                  reload = 1'b1;
                  sr_d   = reload_word;
                  miso_d = first_bit(reload_word, lsb_in);
               end
            end else if (!ss_s) begin
               // ss_n low without a fall seen: never join a frame in progress.
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               state_d     = ST_IDLE;
               miso_d      = 1'b0;
               frame_err_d = (cnt_q != '0);
            end else if (sample_e) begin
               sr_d = shift_in;
               if (cnt_q == LAST_BIT) begin
                  cnt_d     = '0;
                  word_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (drive_e) begin
               // With a zero count this drive edge opens a new word in both phases.
               if (cnt_q == '0) begin
                  reload = 1'b1;
                  sr_d   = reload_word;
                  miso_d = first_bit(reload_word, lsb_q);
               end else begin
                  miso_d = first_bit(sr_q, lsb_q);
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (ss_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (reload) begin
         if (hold_full_q) hold_full_d = 1'b0;
         else             underrun_d  = 1'b1;
      end
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      // Accept first, so a word completing in an accept cycle loads cleanly.
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (word_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         // ss_n chain starts low so a frame already in progress is never seen as a fall.
         sclk_sync_q <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         lsb_q       <= 1'b0;
         sr_q        <= '0;
         cnt_q       <= '0;
         miso_q      <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         ss_sync_q   <= ss_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         ss_prev_q   <= ss_prev_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         lsb_q       <= lsb_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         miso_q      <= miso_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = (state_q == ST_SHIFT);
   assign busy        = (state_q == ST_SHIFT);
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;
   assign rx_overrun  = overrun_q;
   assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a bench-side SPI master plus a word-level model
// (queues of handed-over TX words and expected RX words, event counters).
module tb_spi_slave_sync;
   localparam int HALF = 8;   // clk cycles per sclk phase

   logic clk = 1'b0, rst = 1'b1;
   logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic lsb_m = 1'b0;
   logic [7:0] tx_data = '0;
   logic tx_valid = 1'b0, rx_ready = 1'b1;
   logic miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, rx_overrun, frame_err;
   logic [7:0] rx_data;

   int n_cmp = 0, n_bad = 0;
   logic [7:0] txq[$], rxq[$], feed_q[$];
   int exp_und = 0, exp_ovr = 0, exp_ferr = 0;
   int got_und = 0, got_ovr = 0, got_ferr = 0;
   logic chk_idle = 1'b0;
   logic [7:0] last_rx = '0, next_exp = '0;
   logic [7:0] mo_w [4];
   logic [7:0] mi_w [4];

   spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLV_LSB_FIRST_EN
      .lsb_first(lsb_m),
`endif
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: a reload takes the oldest handed-over word, or zeros plus an underrun.
   task automatic pop_tx(output logic [7:0] w);
      if (txq.size() != 0) w = txq.pop_front();
      else begin
         w = '0;
         exp_und++;
      end
   endtask

   // Model: a completed word is delivered unless an unaccepted word is still held.
   task automatic rx_model(input logic [7:0] w);
      if (rxq.size() != 0 && !rx_ready) exp_ovr++;
      else rxq.push_back(w);
   endtask

   // Compare process: per-cycle output rules, accepted RX words, event pulses.
   always @(negedge clk) begin
      if (!rst) begin
         chk("oe_vs_busy", miso_oe, busy);
         if (!busy) chk("miso_idle", miso, 1'b0);
         if (chk_idle) chk("busy_locked", busy, 1'b0);
         if (tx_valid && tx_ready) txq.push_back(tx_data);
         if (rx_valid && rx_ready) begin
            if (rxq.size() == 0) chk("rx_unexpected", rx_data, 32'hFFFF_FFFF);
            else chk("rx_word", rx_data, rxq.pop_front());
            last_rx = rx_data;
         end
         if (tx_underrun) got_und++;
         if (rx_overrun) got_ovr++;
         if (frame_err) got_ferr++;
      end
   end

   // TX feeder: offers queued words, one handshake at a time.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            @(posedge clk); #1;
            void'(feed_q.pop_front());
            tx_valid = 1'b0;
         end else if (!tx_valid && feed_q.size() != 0 && !rst) begin
            @(posedge clk); #1;
            tx_data  = feed_q[0];
            tx_valid = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic xfer_word(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic [7:0] exp_w;
      int b;
      mi = '0;
      if (cpha) pop_tx(next_exp);   // CPHA=1 reloads on the word's first leading edge
      exp_w = next_exp;
      for (int i = 0; i < nbits; i++) begin
         b = lsb_m ? i : 7 - i;
         if (!cpha) begin
            mosi = mo[b];
            wait_clk(HALF);
            mi[b] = miso;
            sclk = ~cpol;
            if (i == 7) rx_model(mo);
            wait_clk(HALF);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[b];
            wait_clk(HALF);
            mi[b] = miso;
            sclk = cpol;
            if (i == 7) rx_model(mo);
            wait_clk(HALF);
         end
      end
      if (nbits == 8) begin
         chk("miso_word", mi, exp_w);
         // CPHA=0 reloads on the trailing edge after every full word, the last one included.
         if (!cpha) pop_tx(next_exp);
      end
   endtask

   task automatic frame(input int nw, input int last_bits);
      ss_n = 1'b0;
      if (!cpha) pop_tx(next_exp);
      wait_clk(HALF);
      for (int k = 0; k < nw; k++) xfer_word(mo_w[k], (k == nw - 1) ? last_bits : 8, mi_w[k]);
      wait_clk(HALF);
      chk("busy_in_frame", busy, 1'b1);
      ss_n = 1'b1;
      if (last_bits != 8) exp_ferr++;
      wait_clk(2 * HALF);
   endtask

   task automatic set_mode(input logic pol, input logic pha);
      cpol = pol;
      cpha = pha;
      sclk = pol;
      wait_clk(4);
   endtask

   task automatic preload_wait();
      int n = 0;
      while (tx_ready !== 1'b0 && n < 50) begin
         wait_clk(1);
         n++;
      end
      chk("preload_taken", tx_ready, 1'b0);
   endtask

   task automatic check_end(input string nm);
      wait_clk(20);
      chk({nm, "_underruns"}, got_und, exp_und);
      chk({nm, "_overruns"}, got_ovr, exp_ovr);
      chk({nm, "_frame_errs"}, got_ferr, exp_ferr);
      chk({nm, "_rx_pending"}, rxq.size(), 0);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_miso_oe"}, miso_oe, 1'b0);
      chk({nm, "_miso"}, miso, 1'b0);
      chk({nm, "_rx_valid"}, rx_valid, 1'b0);
      chk({nm, "_rx_data"}, rx_data, 8'h00);
      chk({nm, "_tx_ready"}, tx_ready, 1'b1);
      chk({nm, "_pulses"}, {tx_underrun, rx_overrun, frame_err}, 3'b000);
   endtask

   initial begin
      wait_clk(4);
      check_reset_vals("rst0");
      rst = 1'b0;
      wait_clk(10);

      // Mode 0, single word: 0xA5 out, 0x3C in.
      set_mode(1'b0, 1'b0);
      feed_q.push_back(8'hA5);
      preload_wait();
      mo_w[0] = 8'h3C;
      frame(1, 8);
      chk("t1_miso_bits", mi_w[0], 8'hA5);
      chk("t1_rx_data", last_rx, 8'h3C);
      check_end("t1");
      chk("t1_no_rx_events", got_ovr + got_ferr, 0);

      // Three-word burst in every mode.
      for (int m = 0; m < 4; m++) begin
         set_mode(m[1], m[0]);
         feed_q.push_back(8'h11);
         feed_q.push_back(8'h22);
         feed_q.push_back(8'h33);
         preload_wait();
         mo_w[0] = 8'hF0; mo_w[1] = 8'h0F; mo_w[2] = 8'hAA;
         frame(3, 8);
         chk("burst_tx0", mi_w[0], 8'h11);
         chk("burst_tx1", mi_w[1], 8'h22);
         chk("burst_tx2", mi_w[2], 8'h33);
         chk("burst_rx_last", last_rx, 8'hAA);
         check_end("burst");
      end

      // Empty holding register at frame start; 0x55 offered mid-word goes out as word 2.
      set_mode(1'b0, 1'b0);
      mo_w[0] = 8'h00; mo_w[1] = 8'h00;
      fork
         frame(2, 8);
         begin
            wait_clk(30);
            feed_q.push_back(8'h55);
         end
      join
      chk("t3_word1_zero", mi_w[0], 8'h00);
      chk("t3_word2", mi_w[1], 8'h55);
      check_end("t3");

      // rx_ready held low across a two-word burst.
      rx_ready = 1'b0;
      mo_w[0] = 8'h12; mo_w[1] = 8'h34;
      frame(2, 8);
      chk("t4_rx_valid_held", rx_valid, 1'b1);
      chk("t4_rx_data_kept", rx_data, 8'h12);
      chk("t4_one_overrun", got_ovr, exp_ovr);
      rx_ready = 1'b1;
      check_end("t4");

      // ss_n raised after five bits, then a clean 0x81 frame.
      mo_w[0] = 8'hFF;
      frame(1, 5);
      check_end("t5a");
      mo_w[0] = 8'h81;
      frame(1, 8);
      chk("t5_rx_0x81", last_rx, 8'h81);
      check_end("t5b");

      // Reset mid-frame with ss_n held low.
      ss_n = 1'b0;
      pop_tx(next_exp);
      wait_clk(HALF);
      for (int i = 0; i < 3; i++) begin
         mosi = 1'b1; sclk = 1'b1; wait_clk(HALF);
         sclk = 1'b0; wait_clk(HALF);
      end
      chk("t6_busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      wait_clk(2);
      check_reset_vals("t6_rst");
      rst = 1'b0;
      txq.delete();
      rxq.delete();
      chk_idle = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b1; wait_clk(HALF);
         sclk = 1'b0; wait_clk(HALF);
      end
      chk_idle = 1'b0;
      ss_n = 1'b1;
      wait_clk(2 * HALF);
      mo_w[0] = 8'h5A;
      frame(1, 8);
      chk("t6_rx_after_rearm", last_rx, 8'h5A);
      check_end("t6");

`ifdef SPI_SLV_LSB_FIRST_EN
      lsb_m = 1'b1;
      feed_q.push_back(8'h01);
      preload_wait();
      mo_w[0] = 8'h80;
      frame(1, 8);
      chk("lsb_first_bit", mi_w[0][0], 1'b1);
      chk("lsb_rx", last_rx, 8'h80);
      check_end("lsb");
      lsb_m = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
